halflife_decay_timer: RTL and testbench
=======================================

# halflife_decay_timer

Parametrised successor to the 4-bit half-life counter. It holds a WIDTH-bit value that can be loaded or stepped up/down manually. On `start` the value decays autonomously, halving once every latched `half_period` clock ticks until it reaches zero. It then pulses `done`, reports how many halvings occurred, and returns to manual mode. It sits under the Tiny Tapeout top wrapper in place of the fixed-width counter.

## Interface
Parameters:
- `WIDTH`, 8: width of the value (`in`/`out`); minimum 2.
- `PRESCALE_W`, 16: width of the `half_period` input and the internal prescaler.
- `HL_CNT_W`, 4: width of the `halvings` output; saturates at 2^HL_CNT_W−1.

Ports:
- `clk` input 1: single clock; all state changes on its rising edge.
- `reset` input 1: synchronous, active-high reset.
- `up` input 1: increment `out` by 1 in IDLE.
- `down` input 1: decrement `out` by 1 in IDLE.
- `load` input 1: load `in` into `out`; aborts decay.
- `start` input 1: begin decay from the current `out`.
- `in` input WIDTH: load value.
- `half_period` input PRESCALE_W: ticks per half-life; latched on `start`; 0 is treated as 1.
- `out` output WIDTH: current value.
- `halvings` output HL_CNT_W: halvings performed in the current or last decay.
- `busy` output 1: high in DECAY.
- `done` output 1: one-cycle pulse in FINISH.

## Operation
- States: IDLE, DECAY, FINISH. Reset → IDLE.
- Per-edge priority: `reset` > `load` > `start` > `up`/`down`.
- IDLE:
  - `up` alone → `out`+1. `down` alone → `out`−1. Both use modulo 2^WIDTH wrap (max+1→0, 0−1→max).
  - `up` and `down` together → hold.
  - `load` → `out`=`in`, state unchanged.
  - `start` with `out`≠0 → DECAY. Latch P = max(`half_period`,1); clear the prescaler and `halvings`.
  - `start` with `out`=0 → FINISH directly; `halvings` cleared to 0.
- DECAY:
  - The prescaler increments every cycle. When prescaler==P−1: `out`←`out`>>1, `halvings`+1 (saturating), prescaler←0.
  - If the new `out` is 0 → FINISH.
  - `up`, `down` and `start` are ignored. There is no restart.
  - `load` → `out`=`in`, state→IDLE, `halvings` kept.
- FINISH: lasts one cycle, `done`=1, then IDLE. `load` in FINISH is honoured; state still goes to IDLE.
- `half_period` changes during DECAY have no effect.
- `halvings` holds its value in IDLE until the next `start` or `reset`.

## Timing
- Reset values: `out`=0, `halvings`=0, `busy`=0, `done`=0, prescaler=0, state IDLE.
- Manual `up`/`down`/`load`: visible on `out` one cycle after the sampling edge.
- `start` sampled at edge t → `busy`=1 from t+1. The k-th halving appears on `out` after edge t+k·P.
- The edge that produces `out`=0 enters FINISH → `done` high exactly one cycle, with `busy`=0 in that cycle.
- Total decay from V≠0 without rounding: (floor(log2 V)+1)·P cycles.
- `start` with `out`=0 → `done` in cycle t+1.

## Configuration
- `HALFLIFE_ROUND_EN` defined: halving rounds half-up, (`out`+1)>>1, computed at WIDTH+1 bits. Value 1 is forced to 0 so decay always terminates.
- Not defined: truncating `out`>>1.
- Example, V=200, with the macro: 200→100→50→25→13→7→4→2→1→0, 9 halvings.
- Same V without the macro: 8 halvings.

## Structure
- Shared package `halflife_pkg`:
  - state enum `hl_state_t` (IDLE, DECAY, FINISH).
  - constant function for the halving step, so the rounding rule lives in one place.
- Sub-module `halflife_prescaler`:
  - PRESCALE_W counter with `clear` and `enable` inputs and a latched period.
  - Emits a one-cycle `tick` when count==P−1.
- Top-level holds the FSM, the value register and the `halvings` counter.

## Test plan
- Reset then `up`×3 → `out`=3. `down`×4 → `out`=255 (WIDTH=8 wrap). `up`&`down` together → holds 255.
- `load` `in`=200, `start`, `half_period`=3, truncating build → `out` sequence 100,50,25,12,6,3,1,0 every 3 cycles. `done` at cycle 25 after `start`; `halvings`=8.
- Same stimulus with `HALFLIFE_ROUND_EN` → sequence 100,50,25,13,7,4,2,1,0; `halvings`=9; `done` at cycle 28.
- `half_period`=0, `in`=4, `start` → halving every cycle: 2,1,0. `done` at cycle 4. Change `half_period` mid-decay → no effect.
- `load` `in`=9 during DECAY → IDLE, `out`=9, `busy`=0, no `done`. `start` with `out`=0 → `done` next cycle, `halvings`=0.
- `reset` asserted mid-decay → next cycle all outputs 0, IDLE. `start` during DECAY is ignored.

Source files
------------

// File: rtl/halflife_pkg.sv
// Shared state encoding and halving rule for halflife_decay_timer.
// Define HALFLIFE_ROUND_EN to round each halving half-up instead of truncating.
package halflife_pkg;

  // Widest value the halving helper accepts; callers zero-extend into it.
  localparam int unsigned HL_MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECAY  = 2'd1,
    FINISH = 2'd2
  } hl_state_t;

  function automatic logic [HL_MAX_W-1:0] halve_step(input logic [HL_MAX_W-1:0] v);
`ifdef HALFLIFE_ROUND_EN
    // Rounding 1 half-up gives 1 again, so it is forced to 0 to end the decay.
    if (v == HL_MAX_W'(1)) begin
      return '0;
    end
    return (v + HL_MAX_W'(1)) >> 1;
`else
    return v >> 1;
`endif
  endfunction

endpackage

// File: rtl/halflife_prescaler.sv
// Half-life prescaler: counts enabled cycles and emits a one-cycle tick every
// P cycles, where P is latched on clear (a zero period is treated as 1).
module halflife_prescaler #(
  parameter int unsigned PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear_i,
  input  logic                  enable_i,
  input  logic [PRESCALE_W-1:0] period_i,
  output logic                  tick_o
);

  logic [PRESCALE_W-1:0] count_q, count_d;
  logic [PRESCALE_W-1:0] period_q, period_d;

  assign tick_o = enable_i && !clear_i && (count_q == period_q - PRESCALE_W'(1));

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    count_d  = count_q;
    period_d = period_q;
    if (clear_i) begin
      count_d  = '0;
      period_d = (period_i == '0) ? PRESCALE_W'(1) : period_i;
    end else if (enable_i) begin
      count_d = tick_o ? '0 : count_q + PRESCALE_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q  <= '0;
      period_q <= PRESCALE_W'(1);
    end else begin
      count_q  <= count_d;
      period_q <= period_d;
    end
  end

endmodule

// File: rtl/halflife_decay_timer.sv
// Half-life decay timer: manual up/down/load value that decays by halving every
// latched half_period ticks after start. Rounding mode set by HALFLIFE_ROUND_EN.
module halflife_decay_timer
  import halflife_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned PRESCALE_W = 16,
  parameter int unsigned HL_CNT_W   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  up,
  input  logic                  down,
  input  logic                  load,
  input  logic                  start,
  input  logic [WIDTH-1:0]      in,
  input  logic [PRESCALE_W-1:0] half_period,
  output logic [WIDTH-1:0]      out,
  output logic [HL_CNT_W-1:0]   halvings,
  output logic                  busy,
  output logic                  done
);

  hl_state_t             state_q, state_d;
  logic [WIDTH-1:0]      out_q, out_d;
  logic [HL_CNT_W-1:0]   halv_q, halv_d;
  logic [HL_CNT_W-1:0]   halv_inc;
  logic                  presc_clear;
  logic                  presc_en;
  logic                  tick;
  logic [HL_MAX_W-1:0]   halved_full;
  logic [WIDTH-1:0]      halved;
  logic                  unused_halved_hi;

  halflife_prescaler #(
    .PRESCALE_W(PRESCALE_W)
  ) u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (presc_clear),
    .enable_i (presc_en),
    .period_i (half_period),
    .tick_o   (tick)
  );

  // A halved WIDTH-bit value always fits back in WIDTH bits; the upper bits are zero.
  assign halved_full      = halve_step(HL_MAX_W'(out_q));
  assign halved           = halved_full[WIDTH-1:0];
  assign unused_halved_hi = |halved_full[HL_MAX_W-1:WIDTH];

  assign halv_inc = (halv_q == '1) ? halv_q : halv_q + HL_CNT_W'(1);

  always_comb begin
    state_d     = state_q;
    out_d       = out_q;
    halv_d      = halv_q;
    presc_clear = 1'b0;
    presc_en    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (load) begin
          out_d = in;
        end else if (start) begin
          presc_clear = 1'b1;
          halv_d      = '0;
          state_d     = (out_q != '0) ? DECAY : FINISH;
        end else if (up && !down) begin
          out_d = out_q + WIDTH'(1);
        end else if (down && !up) begin
          out_d = out_q - WIDTH'(1);
        end
      end

      DECAY: begin
        if (load) begin
          out_d   = in;
          state_d = IDLE;
        end else begin
          presc_en = 1'b1;
          if (tick) begin
            out_d  = halved;
            halv_d = halv_inc;
            if (halved == '0) begin
              state_d = FINISH;
            end
          end
        end
      end

      FINISH: begin
        state_d = IDLE;
        if (load) begin
          out_d = in;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      out_q   <= '0;
      halv_q  <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      halv_q  <= halv_d;
    end
  end

  assign out      = out_q;
  assign halvings = halv_q;
  assign busy     = (state_q == DECAY);
  assign done     = (state_q == FINISH);

endmodule

// File: tb/tb_halflife_decay_timer.sv
// Self-checking bench for halflife_decay_timer: table vectors for manual mode,
// hand-written decay corner cases, and randomized traffic against a value model.
module tb_halflife_decay_timer;

  localparam int WIDTH      = 8;
  localparam int PRESCALE_W = 16;
  localparam int HL_CNT_W   = 4;
  localparam int VMOD       = 1 << WIDTH;
  localparam int HMAX       = (1 << HL_CNT_W) - 1;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  up, down, load, start;
  logic [WIDTH-1:0]      in_v;
  logic [PRESCALE_W-1:0] half_period;
  logic [WIDTH-1:0]      out;
  logic [HL_CNT_W-1:0]   halvings;
  logic                  busy, done;

  int checks = 0;
  int errors = 0;
  int m_out  = 0;
  int m_halv = 0;
  int last_done_j;

  halflife_decay_timer #(
    .WIDTH(WIDTH), .PRESCALE_W(PRESCALE_W), .HL_CNT_W(HL_CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .up(up), .down(down), .load(load), .start(start),
    .in(in_v), .half_period(half_period), .out(out), .halvings(halvings),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             up, down, load, start;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] e_out;
    logic             e_busy, e_done;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mk(bit u, bit d, bit l, bit s, int din, int eo, bit eb, bit ed);
    vec_t v;
    v.up = u; v.down = d; v.load = l; v.start = s;
    v.din = 8'(din); v.e_out = 8'(eo); v.e_busy = eb; v.e_done = ed;
    return v;
  endfunction

  // Reference halving rule, written as plain integer arithmetic.
  function automatic int model_halve(int x);
`ifdef HALFLIFE_ROUND_EN
    return (x == 1) ? 0 : (x + 1) / 2;
`else
    return x / 2;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    up = 0; down = 0; load = 0; start = 0;
  endtask

  task automatic check_all(input string tag, input int eo, input int eb, input int ed, input int eh);
    check({tag, "_out"}, 32'(out), eo);
    check({tag, "_busy"}, 32'(busy), eb);
    check({tag, "_done"}, 32'(done), ed);
    check({tag, "_halvings"}, 32'(halvings), eh);
  endtask

  task automatic load_val(input int v);
    load = 1; in_v = 8'(v);
    cycle();
    load = 0;
    m_out = v;
    check_all("load", m_out, 0, 0, m_halv);
  endtask

  // Starts a decay from m_out and checks every cycle up to the return to IDLE.
  // Expected state at cycle j after the start edge: floor(j/P) halvings applied.
  task automatic run_decay(input int hp, input int chg_at, input int chg_val, input bit noise);
    int p, n, k, v, x, eo;
    int seq[$];
    v = m_out;
    p = (hp == 0) ? 1 : hp;
    seq = {};
    x = v;
    while (x != 0) begin
      x = model_halve(x);
      seq.push_back(x);
    end
    n = seq.size();
    start = 1; half_period = 16'(hp);
    cycle();
    start = 0;
    check_all("decay_start", v, 1, 0, 0);
    last_done_j = -1;
    for (int j = 1; j <= n * p + 1; j++) begin
      if (noise) begin
        up = 1'($urandom); down = 1'($urandom); start = 1'($urandom);
      end
      if (j == chg_at) half_period = 16'(chg_val);
      cycle();
      if (done === 1'b1 && last_done_j < 0) last_done_j = j;
      k  = (j / p > n) ? n : j / p;
      eo = (k == 0) ? v : seq[k-1];
      if (j < n * p)       check_all("decay_run", eo, 1, 0, (k > HMAX) ? HMAX : k);
      else if (j == n * p) check_all("decay_finish", eo, 0, 1, (n > HMAX) ? HMAX : n);
      else                 check_all("decay_after", eo, 0, 0, (n > HMAX) ? HMAX : n);
    end
    idle_inputs();
    m_out  = 0;
    m_halv = (n > HMAX) ? HMAX : n;
  endtask

  initial begin
    reset = 1; idle_inputs(); in_v = '0; half_period = '0;
    cycle(); cycle();
    check_all("reset", 0, 0, 0, 0);
    reset = 0;

    // Manual-mode vectors.
    vecs[0]  = mk(1, 0, 0, 0,   0,   1, 0, 0);
    vecs[1]  = mk(1, 0, 0, 0,   0,   2, 0, 0);
    vecs[2]  = mk(1, 0, 0, 0,   0,   3, 0, 0);
    vecs[3]  = mk(0, 1, 0, 0,   0,   2, 0, 0);
    vecs[4]  = mk(0, 1, 0, 0,   0,   1, 0, 0);
    vecs[5]  = mk(0, 1, 0, 0,   0,   0, 0, 0);
    vecs[6]  = mk(0, 1, 0, 0,   0, 255, 0, 0);
    vecs[7]  = mk(1, 1, 0, 0,   0, 255, 0, 0);
    vecs[8]  = mk(1, 0, 0, 0,   0,   0, 0, 0);
    vecs[9]  = mk(1, 0, 1, 0, 200, 200, 0, 0);
    vecs[10] = mk(0, 0, 1, 1,   7,   7, 0, 0);
    vecs[11] = mk(0, 1, 0, 0,   0,   6, 0, 0);
    vecs[12] = mk(0, 0, 1, 0,   0,   0, 0, 0);
    vecs[13] = mk(0, 0, 0, 1,   0,   0, 0, 1);
    vecs[14] = mk(0, 0, 0, 0,   0,   0, 0, 0);
    vecs[15] = mk(1, 0, 0, 1,   0,   0, 0, 1);
    vecs[16] = mk(0, 0, 0, 0,   0,   0, 0, 0);
    for (int i = 0; i < 17; i++) begin
      up = vecs[i].up; down = vecs[i].down; load = vecs[i].load; start = vecs[i].start;
      in_v = vecs[i].din; half_period = 16'd5;
      cycle();
      check_all($sformatf("vec%0d", i), 32'(vecs[i].e_out), 32'(vecs[i].e_busy),
                32'(vecs[i].e_done), 0);
    end
    idle_inputs();
    m_out = 0; m_halv = 0;

    // Decay of 200 with half_period 3.
    load_val(200);
    run_decay(3, 0, 0, 1'b0);
`ifdef HALFLIFE_ROUND_EN
    check("done_cycle_200", 32'(last_done_j), 27);
    check("halvings_200", 32'(halvings), 9);
`else
    check("done_cycle_200", 32'(last_done_j), 24);
    check("halvings_200", 32'(halvings), 8);
`endif

    // half_period 0 acts as 1; a change mid-decay has no effect.
    load_val(4);
    run_decay(0, 1, 7, 1'b0);
    check("done_cycle_4", 32'(last_done_j), 3);

    // Load aborts decay: back to IDLE, halvings kept, no done.
    load_val(100);
    start = 1; half_period = 16'd2;
    cycle();
    start = 0;
    repeat (3) cycle();
    load = 1; in_v = 8'd9;
    cycle();
    load = 0;
    check_all("abort", 9, 0, 0, 1);
    cycle();
    check_all("abort_after", 9, 0, 0, 1);
    m_out = 9; m_halv = 1;

    // Start with out=0 finishes next cycle.
    load_val(0);
    start = 1;
    cycle();
    start = 0;
    check_all("zero_start", 0, 0, 1, 0);
    cycle();
    check_all("zero_after", 0, 0, 0, 0);
    m_halv = 0;

    // Load during the FINISH cycle is honoured.
    load_val(4);
    start = 1; half_period = 16'd1;
    cycle();
    start = 0;
    repeat (3) cycle();
    check_all("fin_cycle", 0, 0, 1, 3);
    load = 1; in_v = 8'd33;
    cycle();
    load = 0;
    check_all("fin_load", 33, 0, 0, 3);
    up = 1;
    cycle();
    up = 0;
    check_all("fin_up", 34, 0, 0, 3);
    m_out = 34; m_halv = 3;

    // Start during decay ignored, then reset mid-decay.
    load_val(64);
    start = 1; half_period = 16'd2;
    cycle();
    start = 0;
    cycle();
    start = 1;
    cycle();
    start = 0;
    check_all("restart_ignored", 32, 1, 0, 1);
    reset = 1;
    cycle();
    reset = 0;
    check_all("mid_reset", 0, 0, 0, 0);
    cycle();
    check_all("mid_reset_idle", 0, 0, 0, 0);
    up = 1;
    cycle();
    up = 0;
    check_all("mid_reset_up", 1, 0, 0, 0);
    m_out = 1; m_halv = 0;

    // Randomized traffic.
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(2) == 0) begin
        for (int c = 0; c < 5; c++) begin
          up = 1'($urandom); down = 1'($urandom); load = ($urandom_range(3) == 0);
          in_v = 8'($urandom);
          cycle();
          if (load)               m_out = int'(in_v);
          else if (up && !down)   m_out = (m_out + 1) % VMOD;
          else if (down && !up)   m_out = (m_out + VMOD - 1) % VMOD;
          idle_inputs();
          check_all("rand_manual", m_out, 0, 0, m_halv);
        end
      end else begin
        load_val($urandom_range(255, 1));
        run_decay($urandom_range(4), $urandom_range(6, 1), $urandom_range(5), 1'b1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
